// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and
// emits them one bit per clock on ser_out, streaming back-to-back words gap-free.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic             last;
  logic             accept;

  assign last     = (state == SHIFT) && (cnt == LAST);
  assign in_ready = (state == IDLE) || last;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == SHIFT);

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // ser_out is registered one bit ahead, so sr holds only the bits not yet shown.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      ser_out   <= IDLE_BIT;
      ser_valid <= 1'b0;
      word_done <= 1'b0;
    end else if (accept) begin
      state     <= SHIFT;
      cnt       <= '0;
      sr        <= advance(in_data);
      ser_out   <= first_bit(in_data);
      ser_valid <= 1'b1;
      word_done <= (WIDTH == 1);
    end else if ((state == SHIFT) && !last) begin
      cnt       <= cnt + CW'(1);
      sr        <= advance(sr);
      ser_out   <= first_bit(sr);
      ser_valid <= 1'b1;
      word_done <= (cnt == PENULT);
    end else begin
      state     <= IDLE;
      cnt       <= '0;
      ser_out   <= IDLE_BIT;
      ser_valid <= 1'b0;
      word_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Randomized bench for bit_serializer: three configurations checked each cycle
// against an index-based model of which word bit should be on the line.
module tb_bit_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  iv = '0;
  logic [63:0] dat [3];
  logic [2:0]  so, sv, wd, bz, rdy;

  logic [7:0] d8;
  logic [3:0] d4;
  logic [0:0] d1;
  assign d8 = dat[0][7:0];
  assign d4 = dat[1][3:0];
  assign d1 = dat[2][0:0];

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy[0]), .in_data(d8),
    .ser_out(so[0]), .ser_valid(sv[0]), .busy(bz[0]), .word_done(wd[0]));

  bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy[1]), .in_data(d4),
    .ser_out(so[1]), .ser_valid(sv[1]), .busy(bz[1]), .word_done(wd[1]));

  bit_serializer #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy[2]), .in_data(d1),
    .ser_out(so[2]), .ser_valid(sv[2]), .busy(bz[2]), .word_done(wd[2]));

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: the word being shown and the index (in shift order) of the bit on the line.
  int          mw   [3] = '{8, 4, 1};
  bit          msb  [3] = '{1'b1, 1'b0, 1'b1};
  bit          idle [3] = '{1'b0, 1'b1, 1'b0};
  logic [63:0] word [3];
  int          pos  [3] = '{-1, -1, -1};

  logic [63:0] q0[$] = '{64'hA5, 64'h3C, 64'hFF, 64'h81};
  logic [63:0] q1[$] = '{64'hD, 64'hB, 64'h6};
  logic [63:0] q2[$] = '{64'h1, 64'h0, 64'h1, 64'h1};

  function automatic bit model_ready(input int d);
    return (pos[d] < 0) || (pos[d] == mw[d] - 1);
  endfunction

  function automatic logic [63:0] rand_word(input int d);
    logic [63:0] m;
    m = (64'd1 << mw[d]) - 64'd1;
    return {$urandom, $urandom} & m;
  endfunction

  function automatic logic [63:0] next_word(input int d);
    logic [63:0] w;
    w = rand_word(d);
    case (d)
      0: if (q0.size() > 0) w = q0.pop_front();
      1: if (q1.size() > 0) w = q1.pop_front();
      default: if (q2.size() > 0) w = q2.pop_front();
    endcase
    return w;
  endfunction

  initial begin
    logic exp_bit;
    for (int d = 0; d < 3; d++) begin
      dat[d]  = '0;
      word[d] = '0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst = (cyc < 2) || ($urandom_range(0, 59) == 0);
      for (int d = 0; d < 3; d++) begin
        check($sformatf("d%0d in_ready", d), {63'd0, rdy[d]}, {63'd0, model_ready(d)});
        if (!iv[d]) begin
          if (cyc < 40 || $urandom_range(0, 3) != 0) begin
            iv[d]  = 1'b1;
            dat[d] = next_word(d);
          end
        end else if (!model_ready(d) && $urandom_range(0, 4) == 0) begin
          dat[d] = rand_word(d);
        end
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        if (rst) begin
          pos[d] = -1;
        end else if (iv[d] && model_ready(d)) begin
          word[d] = dat[d];
          pos[d]  = 0;
          iv[d]   = 1'b0;
        end else if (pos[d] >= 0) begin
          pos[d]++;
          if (pos[d] == mw[d]) pos[d] = -1;
        end
        if (pos[d] >= 0)
          exp_bit = msb[d] ? word[d][mw[d] - 1 - pos[d]] : word[d][pos[d]];
        else
          exp_bit = idle[d];
        check($sformatf("d%0d ser_out", d),   {63'd0, so[d]}, {63'd0, exp_bit});
        check($sformatf("d%0d ser_valid", d), {63'd0, sv[d]}, {63'd0, pos[d] >= 0});
        check($sformatf("d%0d busy", d),      {63'd0, bz[d]}, {63'd0, pos[d] >= 0});
        check($sformatf("d%0d word_done", d), {63'd0, wd[d]}, {63'd0, pos[d] == mw[d] - 1});
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
